calc_display_ctrl: RTL and testbench

Parametrised N-digit calculator display controller. Holds a BCD digit register file. Accepts one command per cycle: direct write, calculator-style shift entry, backspace, clear and sign toggle. Drives N seven-segment digits with leading-digit blanking and a minus sign, and sits between the keypad decoder and the board displays in the top level.

---
 rtl/calc_display_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_calc_display_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_display_ctrl.sv
// N-digit BCD calculator display controller: digit entry, sign and 7-segment drive.
// Optional cursor blink is enabled with `define CURSOR_BLINK_EN.
module calc_display_ctrl #(
  parameter int N_DIGITS  = 8,
  parameter int PW        = 5,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            cmd_valid,
  input  logic [2:0]                      cmd_op,
  input  logic [3:0]                      cmd_dig,
  input  logic [PW-1:0]                   cmd_pos,
  output logic [7*N_DIGITS-1:0]           seg,
  output logic [$clog2(N_DIGITS+1)-1:0]   digit_count,
  output logic                            negative,
  output logic                            full,
  output logic                            err
);

  localparam int CW = $clog2(N_DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N_DIGITS);
  localparam logic [CW-1:0] CNT_TOP = CW'(N_DIGITS - 1);
  localparam logic [PW-1:0] POS_MAX = PW'(N_DIGITS);

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_WRITE  = 3'd1,
    OP_SHIFT  = 3'd2,
    OP_BACK   = 3'd3,
    OP_CLEAR  = 3'd4,
    OP_NEGATE = 3'd5
  } cmd_op_e;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  logic [3:0]            r_dig [N_DIGITS];
  logic [CW-1:0]         r_count;
  logic                  r_neg;
  logic                  r_err;
  logic                  r_full;
  logic [7*N_DIGITS-1:0] r_seg;

  logic [3:0]            w_dig [N_DIGITS];
  logic [CW-1:0]         w_count;
  logic                  w_neg;
  logic                  w_reject;
  logic [CW-1:0]         w_k;
  logic [CW-1:0]         w_cur;
  logic                  w_cursor_on;
  logic [7*N_DIGITS-1:0] w_seg;

  // Command decode: next digit file, count and sign; rejected commands keep state.
  always_comb begin
    w_dig    = r_dig;
    w_count  = r_count;
    w_neg    = r_neg;
    w_reject = 1'b0;
    if (cmd_valid) begin
      case (cmd_op)
        OP_NOP: begin
          w_reject = 1'b0;
        end
        OP_WRITE: begin
          if (cmd_pos == {PW{1'b0}} || cmd_pos > POS_MAX || cmd_dig > 4'd9 ||
              (r_neg && cmd_pos == POS_MAX)) begin
            w_reject = 1'b1;
          end else begin
            for (int i = 0; i < N_DIGITS; i++)
              w_dig[i] = (cmd_pos == PW'(i + 1)) ? cmd_dig : r_dig[i];
            w_count = (CW'(cmd_pos) > r_count) ? CW'(cmd_pos) : r_count;
          end
        end
        OP_SHIFT: begin
          if (cmd_dig > 4'd9 || r_count == CNT_MAX || (r_neg && r_count == CNT_TOP)) begin
            w_reject = 1'b1;
          end else if (r_count == {CW{1'b0}} && cmd_dig == 4'd0) begin
            w_dig[0] = 4'd0;
          end else begin
            for (int i = 1; i < N_DIGITS; i++) w_dig[i] = r_dig[i-1];
            w_dig[0] = cmd_dig;
            w_count  = r_count + CW'(1);
          end
        end
        OP_BACK: begin
          for (int i = 0; i < N_DIGITS - 1; i++) w_dig[i] = r_dig[i+1];
          w_dig[N_DIGITS-1] = 4'd0;
          if (r_count == {CW{1'b0}}) begin
            w_neg = 1'b0;
          end else begin
            w_count = r_count - CW'(1);
            w_neg   = (r_count == CW'(1)) ? 1'b0 : r_neg;
          end
        end
        OP_CLEAR: begin
          for (int i = 0; i < N_DIGITS; i++) w_dig[i] = 4'd0;
          w_count = {CW{1'b0}};
          w_neg   = 1'b0;
        end
        OP_NEGATE: begin
          if (r_count == CNT_MAX || (r_count == {CW{1'b0}} && r_dig[0] == 4'd0)) begin
            w_reject = 1'b1;
          end else begin
            w_neg = ~r_neg;
          end
        end
        default: begin
          w_reject = 1'b1;
        end
      endcase
    end else begin
      w_reject = 1'b0;
    end
  end

  assign w_k   = (r_count == {CW{1'b0}}) ? CW'(1) : r_count;
  assign w_cur = r_count + CW'(r_neg);

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;

  // Free-running cursor phase generator; only reset returns it to phase 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_blink_cnt <= {BW{1'b0}};
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
      r_blink_cnt <= {BW{1'b0}};
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  assign w_cursor_on = r_phase && (r_count != {CW{1'b0}}) && (w_cur < CNT_MAX);
`else
  assign w_cursor_on = 1'b0;
`endif

  // Display mapping from current state: digits, sign above them, optional cursor.
  always_comb begin
    w_seg = {7*N_DIGITS{1'b0}};
    for (int i = 0; i < N_DIGITS; i++) begin
      if (CW'(i) < w_k) begin
        w_seg[7*i +: 7] = seg7(r_dig[i]);
      end else if (r_neg && CW'(i) == w_k) begin
        w_seg[7*i +: 7] = 7'b0000001;
      end else if (w_cursor_on && CW'(i) == w_cur) begin
        w_seg[7*i +: 7] = 7'b0001000;
      end else begin
        w_seg[7*i +: 7] = 7'b0000000;
      end
    end
  end

  // State, status flags and segment register.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_DIGITS; i++) r_dig[i] <= 4'd0;
      r_count <= {CW{1'b0}};
      r_neg   <= 1'b0;
      r_err   <= 1'b0;
      r_full  <= 1'b0;
      r_seg   <= {{(7*(N_DIGITS-1)){1'b0}}, 7'b1111110};
    end else begin
      r_dig   <= w_dig;
      r_count <= w_count;
      r_neg   <= w_neg;
      r_err   <= w_reject;
      r_full  <= (w_count == CNT_MAX);
      r_seg   <= w_seg;
    end
  end

  assign seg         = r_seg;
  assign digit_count = r_count;
  assign negative    = r_neg;
  assign full        = r_full;
  assign err         = r_err;

endmodule

// File: tb/tb_calc_display_ctrl.sv
// Directed self-checking bench for calc_display_ctrl (N_DIGITS=8).
module tb_calc_display_ctrl;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_WRITE  = 3'd1;
  localparam logic [2:0] OP_SHIFT  = 3'd2;
  localparam logic [2:0] OP_BACK   = 3'd3;
  localparam logic [2:0] OP_CLEAR  = 3'd4;
  localparam logic [2:0] OP_NEGATE = 3'd5;
  localparam logic [2:0] OP_ILL    = 3'd7;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_dig;
  logic [4:0]  cmd_pos;
  logic [55:0] seg;
  logic [3:0]  digit_count;
  logic        negative;
  logic        full;
  logic        err;

  int checks_s = 0;
  int errors_s = 0;

  calc_display_ctrl #(.N_DIGITS(8), .PW(5), .BLINK_DIV(4)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_dig     (cmd_dig),
    .cmd_pos     (cmd_pos),
    .seg         (seg),
    .digit_count (digit_count),
    .negative    (negative),
    .full        (full),
    .err         (err)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] enc(input byte c);
    case (c)
      "0": enc = 7'b1111110;
      "1": enc = 7'b0110000;
      "2": enc = 7'b1101101;
      "3": enc = 7'b1111001;
      "4": enc = 7'b0110011;
      "5": enc = 7'b1011011;
      "6": enc = 7'b1011111;
      "7": enc = 7'b1110000;
      "8": enc = 7'b1111111;
      "9": enc = 7'b1111011;
      "-": enc = 7'b0000001;
      "_": enc = 7'b0001000;
      default: enc = 7'b0000000;
    endcase
  endfunction

  // s is written left to right as seen on the board: s[0] is digit 7
  function automatic logic [55:0] disp(input string s);
    logic [55:0] r;
    r = 56'd0;
    for (int i = 0; i < 8; i++) r[7*i +: 7] = enc(s[7-i]);
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_s++;
    if (got !== exp) begin
      errors_s++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one command for a single edge; returns at the following negedge.
  task automatic cmd(input logic [2:0] op, input logic [3:0] dig, input logic [4:0] pos);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dig   = dig;
    cmd_pos   = pos;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_dig   = 4'd0;
    cmd_pos   = 5'd0;
    @(negedge clock);
    do_reset();
    check_eq("rst_seg", seg, disp("       0"));
    check_eq("rst_cnt", digit_count, 4'd0);
    check_eq("rst_neg", negative, 1'b0);
    check_eq("rst_full", full, 1'b0);
    check_eq("rst_err", err, 1'b0);

    // shift entry
    for (int d = 1; d <= 3; d++) begin
      cmd(OP_SHIFT, 4'(d), 5'd0);
      check_eq("shift_err", err, 1'b0);
    end
    check_eq("shift_cnt", digit_count, 4'd3);
    tick(1);
    check_eq("shift_seg", seg, disp("     123"));

    // leading zeros are not counted
    cmd(OP_CLEAR, 4'd0, 5'd0);
    cmd(OP_SHIFT, 4'd0, 5'd0);
    cmd(OP_SHIFT, 4'd0, 5'd0);
    check_eq("lz_cnt0", digit_count, 4'd0);
    cmd(OP_SHIFT, 4'd5, 5'd0);
    check_eq("lz_cnt", digit_count, 4'd1);
    tick(1);
    check_eq("lz_seg", seg, disp("       5"));

    // full register, rejected shift and negate
    cmd(OP_CLEAR, 4'd0, 5'd0);
    for (int d = 1; d <= 8; d++) cmd(OP_SHIFT, 4'(d), 5'd0);
    check_eq("full_flag", full, 1'b1);
    check_eq("full_cnt", digit_count, 4'd8);
    cmd(OP_SHIFT, 4'd9, 5'd0);
    check_eq("full_shift_err", err, 1'b1);
    tick(1);
    check_eq("err_pulse", err, 1'b0);
    check_eq("full_seg", seg, disp("12345678"));
    cmd(OP_NEGATE, 4'd0, 5'd0);
    check_eq("full_neg_err", err, 1'b1);
    check_eq("full_neg", negative, 1'b0);

    // negate and backspace
    cmd(OP_CLEAR, 4'd0, 5'd0);
    check_eq("clr_full", full, 1'b0);
    cmd(OP_NEGATE, 4'd0, 5'd0);
    check_eq("neg_zero_err", err, 1'b1);
    cmd(OP_SHIFT, 4'd4, 5'd0);
    cmd(OP_SHIFT, 4'd2, 5'd0);
    cmd(OP_NEGATE, 4'd0, 5'd0);
    check_eq("neg_err", err, 1'b0);
    check_eq("neg_flag", negative, 1'b1);
    tick(1);
    check_eq("neg_seg", seg, disp("     -42"));
    cmd(OP_BACK, 4'd0, 5'd0);
    check_eq("bs1_cnt", digit_count, 4'd1);
    check_eq("bs1_neg", negative, 1'b1);
    tick(1);
    check_eq("bs1_seg", seg, disp("      -4"));
    cmd(OP_BACK, 4'd0, 5'd0);
    check_eq("bs2_cnt", digit_count, 4'd0);
    check_eq("bs2_neg", negative, 1'b0);
    tick(1);
    check_eq("bs2_seg", seg, disp("       0"));
    cmd(OP_BACK, 4'd0, 5'd0);
    check_eq("bs0_err", err, 1'b0);
    check_eq("bs0_cnt", digit_count, 4'd0);

    // direct write
    cmd(OP_WRITE, 4'd1, 5'd9);
    check_eq("wr_pos9_err", err, 1'b1);
    cmd(OP_WRITE, 4'd1, 5'd0);
    check_eq("wr_pos0_err", err, 1'b1);
    cmd(OP_WRITE, 4'd10, 5'd2);
    check_eq("wr_bcd_err", err, 1'b1);
    check_eq("wr_rej_cnt", digit_count, 4'd0);
    cmd(OP_WRITE, 4'd7, 5'd4);
    check_eq("wr_err", err, 1'b0);
    check_eq("wr_cnt", digit_count, 4'd4);
    tick(1);
    check_eq("wr_seg", seg, disp("    7000"));
    cmd(OP_WRITE, 4'd3, 5'd2);
    check_eq("wr_low_cnt", digit_count, 4'd4);
    cmd(OP_ILL, 4'd1, 5'd1);
    check_eq("ill_err", err, 1'b1);
    check_eq("ill_cnt", digit_count, 4'd4);
    tick(1);
    check_eq("ill_seg", seg, disp("    7030"));

    // strobe low ignores the op lines
    cmd_valid = 1'b0;
    cmd_op    = OP_CLEAR;
    tick(2);
    cmd_op    = OP_NOP;
    check_eq("novalid_err", err, 1'b0);
    check_eq("novalid_cnt", digit_count, 4'd4);

    // negative number one short of full blocks the last digit
    cmd(OP_CLEAR, 4'd0, 5'd0);
    for (int d = 1; d <= 7; d++) cmd(OP_SHIFT, 4'(d), 5'd0);
    cmd(OP_NEGATE, 4'd0, 5'd0);
    check_eq("n7_neg", negative, 1'b1);
    cmd(OP_SHIFT, 4'd8, 5'd0);
    check_eq("n7_shift_err", err, 1'b1);
    cmd(OP_WRITE, 4'd8, 5'd8);
    check_eq("n7_wr_err", err, 1'b1);
    tick(1);
    check_eq("n7_seg", seg, disp("-1234567"));
    check_eq("n7_cnt", digit_count, 4'd7);

`ifdef CURSOR_BLINK_EN
    begin
      int n_cur;
      int n_blank;
      cmd(OP_CLEAR, 4'd0, 5'd0);
      cmd(OP_SHIFT, 4'd5, 5'd0);
      tick(3);
      do_reset();
      check_eq("blink_rst_seg", seg, disp("       0"));
      cmd(OP_SHIFT, 4'd5, 5'd0);
      tick(1);
      check_eq("blink_phase0", seg, disp("       5"));
      n_cur   = 0;
      n_blank = 0;
      for (int i = 0; i < 16; i++) begin
        if (seg == disp("      _5")) n_cur++;
        else if (seg == disp("       5")) n_blank++;
        tick(1);
      end
      check_eq("blink_cur", 64'(n_cur), 64'd8);
      check_eq("blink_blank", 64'(n_blank), 64'd8);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks_s, errors_s);
    $finish;
  end

endmodule
